// File: rtl/fma16_align_add.sv
// FMA alignment/add stage: aligns the multiplier product against the half-precision addend
// and forms the unnormalized signed sum. Define FMA16_STICKY_EN to keep shifted-out bits as sticky.
module fma16_align_add (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        p_sign,
    input  logic [6:0]  p_exp,
    input  logic [21:0] p_frac,
    input  logic [15:0] z,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        s_sign,
    output logic [6:0]  s_exp,
    output logic [22:0] s_mag,
    output logic        s_sticky,
    output logic        s_zero
);

    logic vld_p1, vld_p2;
    logic s1_adv, s2_load;

    logic              z_nz;
    logic [4:0]        ze;
    logic [10:0]       zsig;
    logic [21:0]       zfrac_ext;
    logic signed [7:0] pexp_s, ze_s, d;
    logic [7:0]        shamt;
    logic [21:0]       pa_c, za_c;
    logic [6:0]        exp_c;

    logic [21:0] pa_p1, za_p1;
    logic [6:0]  exp_p1;
    logic        psign_p1, zsign_p1;

    logic        eff_sub, borrow, sign_c, zero_c;
    logic [22:0] mag_c;

    logic        sign_p2, zero_p2;
    logic [6:0]  exp_p2;
    logic [22:0] mag_p2;

`ifdef FMA16_STICKY_EN
    logic stk_c, stk_p1, stk_p2;
`endif

    function automatic logic [21:0] align_shift(input logic [21:0] v, input logic [7:0] sh);
        if (sh >= 8'd24) return 22'd0;
        return v >> sh;
    endfunction

`ifdef FMA16_STICKY_EN
    function automatic logic lost_bits(input logic [21:0] v, input logic [7:0] sh);
        logic [21:0] mask;
        if (sh >= 8'd22) return |v;
        mask = ~(22'h3FFFFF << sh);
        return |(v & mask);
    endfunction
`endif

    // A borrowed LSB stands in for the truncated tail of the smaller operand.
    function automatic logic [22:0] sub_mag(input logic [21:0] a, input logic [21:0] b,
                                            input logic bw);
        logic [22:0] hi, lo;
        if (a == b) return 23'd0;
        hi = (a > b) ? {1'b0, a} : {1'b0, b};
        lo = (a > b) ? {1'b0, b} : {1'b0, a};
        return hi - lo - {22'd0, bw};
    endfunction

    assign s2_load  = !vld_p2 | out_ready;
    assign s1_adv   = !vld_p1 | s2_load;
    assign in_ready = !vld_p1 | s1_adv;

    always_comb begin
        z_nz      = |z[14:10];
        zsig      = {z_nz, z[9:0]};
        zfrac_ext = {1'b0, zsig, 10'b0};
        ze        = z_nz ? z[14:10] : 5'd1;
        ze_s      = signed'({3'b000, ze});
        pexp_s    = signed'({p_exp[6], p_exp});
        d         = pexp_s - ze_s;
        shamt     = d[7] ? unsigned'(-d) : unsigned'(d);
        if (!d[7]) begin
            pa_c  = p_frac;
            za_c  = align_shift(zfrac_ext, shamt);
            exp_c = p_exp;
        end else begin
            pa_c  = align_shift(p_frac, shamt);
            za_c  = zfrac_ext;
            exp_c = {2'b00, ze};
        end
`ifdef FMA16_STICKY_EN
        stk_c = lost_bits(d[7] ? p_frac : zfrac_ext, shamt);
`endif
    end

    // stage 1: aligned operands
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) vld_p1 <= 1'b0;
        else if (s1_adv) vld_p1 <= in_valid;
    end

    always_ff @(posedge clk) begin
        if (s1_adv && in_valid) begin
            pa_p1    <= pa_c;
            za_p1    <= za_c;
            exp_p1   <= exp_c;
            psign_p1 <= p_sign;
            zsign_p1 <= z[15];
`ifdef FMA16_STICKY_EN
            stk_p1   <= stk_c;
`endif
        end
    end

    always_comb begin
        eff_sub = psign_p1 ^ zsign_p1;
`ifdef FMA16_STICKY_EN
        borrow = stk_p1;
`else
        borrow = 1'b0;
`endif
        if (eff_sub) begin
            mag_c  = sub_mag(pa_p1, za_p1, borrow);
            sign_c = (pa_p1 >= za_p1) ? psign_p1 : zsign_p1;
        end else begin
            mag_c  = {1'b0, pa_p1} + {1'b0, za_p1};
            sign_c = psign_p1;
        end
        zero_c = (mag_c == 23'd0);
        if (zero_c) sign_c = 1'b0;
    end

    // stage 2: signed sum presented to round/normalize
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_p2  <= 1'b0;
            sign_p2 <= 1'b0;
            exp_p2  <= 7'd0;
            mag_p2  <= 23'd0;
            zero_p2 <= 1'b0;
`ifdef FMA16_STICKY_EN
            stk_p2  <= 1'b0;
`endif
        end else if (s2_load) begin
            vld_p2 <= vld_p1;
            if (vld_p1) begin
                sign_p2 <= sign_c;
                exp_p2  <= exp_p1;
                mag_p2  <= mag_c;
                zero_p2 <= zero_c;
`ifdef FMA16_STICKY_EN
                stk_p2  <= stk_p1;
`endif
            end
        end
    end

    assign out_valid = vld_p2;
    assign s_sign    = sign_p2;
    assign s_exp     = exp_p2;
    assign s_mag     = mag_p2;
    assign s_zero    = zero_p2;
`ifdef FMA16_STICKY_EN
    assign s_sticky  = stk_p2;
`else
    assign s_sticky  = 1'b0;
`endif

endmodule

// File: tb/tb_fma16_align_add.sv
// Scoreboard bench for fma16_align_add: directed beats push expected sums, a negedge monitor
// pops and compares whenever a result is handed off, and checks that stalled outputs hold.
module tb_fma16_align_add;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_valid, in_ready;
    logic        p_sign;
    logic [6:0]  p_exp;
    logic [21:0] p_frac;
    logic [15:0] z;
    logic        out_valid, out_ready;
    logic        s_sign, s_sticky, s_zero;
    logic [6:0]  s_exp;
    logic [22:0] s_mag;

    always #5 clk = ~clk;

    fma16_align_add dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
        .p_sign(p_sign), .p_exp(p_exp), .p_frac(p_frac), .z(z),
        .out_valid(out_valid), .out_ready(out_ready),
        .s_sign(s_sign), .s_exp(s_exp), .s_mag(s_mag), .s_sticky(s_sticky), .s_zero(s_zero)
    );

`ifdef FMA16_STICKY_EN
    localparam logic STK = 1'b1;
`else
    localparam logic STK = 1'b0;
`endif

    typedef struct packed {
        logic        sign;
        logic [6:0]  exp;
        logic [21:0] frac;
        logic [15:0] z;
    } beat_t;

    typedef struct packed {
        logic        sign;
        logic [6:0]  exp;
        logic [22:0] mag;
        logic        sticky;
        logic        zero;
    } res_t;

    res_t exp_q[$];
    int   passed = 0;
    int   total  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act === req) passed++;
        else $display("FAIL %s: got %0h, required %0h", name, act, req);
    endtask

    initial begin : monitor
        res_t cur, prev, e;
        logic prev_stall;
        prev_stall = 1'b0;
        prev = '0;
        forever begin
            @(negedge clk);
            cur = {s_sign, s_exp, s_mag, s_sticky, s_zero};
            if (!reset_n) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    check("hold_valid", {63'd0, out_valid}, 64'd1);
                    check("hold_fields", {31'd0, cur}, {31'd0, prev});
                end
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        total++;
                        $display("FAIL unexpected_output: got beat mag %0h, required no output", s_mag);
                    end else begin
                        e = exp_q.pop_front();
                        check("s_sign",   {63'd0, s_sign},   {63'd0, e.sign});
                        check("s_exp",    {57'd0, s_exp},    {57'd0, e.exp});
                        check("s_mag",    {41'd0, s_mag},    {41'd0, e.mag});
                        check("s_sticky", {63'd0, s_sticky}, {63'd0, e.sticky});
                        check("s_zero",   {63'd0, s_zero},   {63'd0, e.zero});
                    end
                end
                prev_stall = out_valid && !out_ready;
                prev = cur;
            end
        end
    end

    task automatic send(input beat_t b, input res_t e, input bit keep);
        int guard;
        @(posedge clk); #1;
        in_valid = 1'b1;
        p_sign   = b.sign;
        p_exp    = b.exp;
        p_frac   = b.frac;
        z        = b.z;
        guard    = 0;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            guard++;
            if (guard > 50) begin
                total++;
                $display("FAIL send_timeout: in_ready got 0, required 1");
                in_valid = 1'b0;
                return;
            end
        end
        if (keep) exp_q.push_back(e);
    endtask

    task automatic idle();
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic single(input beat_t b, input res_t e);
        send(b, e, 1'b1);
        idle();
        @(negedge clk);
        check("latency_early", {63'd0, out_valid}, 64'd0);
        @(negedge clk);
        check("latency_two", {63'd0, out_valid}, 64'd1);
    endtask

    beat_t v1, v2, v3, v4, v5, v6, v7, v8, v9, v10;
    res_t  r1, r2, r3, r4, r5, r6, r7, r8, r9, r10;

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish, required finish");
        $fatal(1);
    end

    initial begin
        v1  = beat_t'{1'b0, 7'd15,  22'h100000, 16'h3C00};
        r1  = res_t'{1'b0, 7'd15, 23'h200000, 1'b0, 1'b0};
        v2  = beat_t'{1'b0, 7'd15,  22'h100000, 16'hBC00};
        r2  = res_t'{1'b0, 7'd15, 23'h000000, 1'b0, 1'b1};
        v3  = beat_t'{1'b0, 7'd15,  22'h100000, 16'h0401};
        r3  = res_t'{1'b0, 7'd15, 23'h100040, STK, 1'b0};
        v4  = beat_t'{1'b0, 7'h6C,  22'h100000, 16'h3C00};
        r4  = res_t'{1'b0, 7'd15, 23'h100000, STK, 1'b0};
        v5  = beat_t'{1'b0, 7'd15,  22'h100000, 16'hC000};
        r5  = res_t'{1'b1, 7'd16, 23'h080000, 1'b0, 1'b0};
        v6  = beat_t'{1'b1, 7'd15,  22'h100000, 16'h0401};
        r6  = res_t'{1'b1, 7'd15, STK ? 23'h0FFFBF : 23'h0FFFC0, STK, 1'b0};
        v7  = beat_t'{1'b0, 7'd1,   22'h100000, 16'h0001};
        r7  = res_t'{1'b0, 7'd1,  23'h100400, 1'b0, 1'b0};
        v8  = beat_t'{1'b0, 7'd15,  22'h300000, 16'h3C00};
        r8  = res_t'{1'b0, 7'd15, 23'h400000, 1'b0, 1'b0};
        v9  = beat_t'{1'b0, 7'h7F,  22'h200000, 16'h0400};
        r9  = res_t'{1'b0, 7'd1,  23'h180000, 1'b0, 1'b0};
        v10 = beat_t'{1'b1, 7'd0,   22'h000000, 16'h8000};
        r10 = res_t'{1'b0, 7'd1,  23'h000000, 1'b0, 1'b1};

        reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        p_sign = 1'b0; p_exp = 7'd0; p_frac = 22'd0; z = 16'd0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_in_ready",  {63'd0, in_ready},  64'd1);
        check("rst_fields", {31'd0, s_sign, s_exp, s_mag, s_sticky, s_zero}, 64'd0);
        @(negedge clk);
        reset_n = 1'b1;

        single(v1, r1);
        single(v2, r2);
        single(v3, r3);
        single(v4, r4);
        single(v5, r5);
        single(v6, r6);
        single(v7, r7);
        single(v8, r8);
        single(v9, r9);
        single(v10, r10);

        @(posedge clk); #1;
        out_ready = 1'b0;
        fork
            begin
                send(v1, r1, 1'b1);
                send(v5, r5, 1'b1);
                send(v8, r8, 1'b1);
                send(v3, r3, 1'b1);
                idle();
            end
            begin
                int g;
                g = 0;
                do begin
                    @(negedge clk);
                    g++;
                end while (!out_valid && g < 50);
                check("stall_out_valid", {63'd0, out_valid}, 64'd1);
                check("stall_in_ready",  {63'd0, in_ready},  64'd0);
                repeat (3) @(negedge clk);
                @(posedge clk); #1;
                out_ready = 1'b1;
                for (int i = 0; i < 4; i++) begin
                    @(negedge clk);
                    check("no_gap", {63'd0, out_valid}, 64'd1);
                end
            end
        join
        repeat (3) @(negedge clk);

        send(v1, r1, 1'b0);
        send(v8, r8, 1'b0);
        idle();
        #1;
        reset_n = 1'b0;
        #1;
        check("midrst_out_valid", {63'd0, out_valid}, 64'd0);
        check("midrst_in_ready",  {63'd0, in_ready},  64'd1);
        check("midrst_fields", {31'd0, s_sign, s_exp, s_mag, s_sticky, s_zero}, 64'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (4) @(negedge clk);
        check("post_rst_idle", {63'd0, out_valid}, 64'd0);
        single(v5, r5);

        repeat (3) @(negedge clk);
        check("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/fma16_align_add.md
FMA16_ALIGN_ADD -- requirements
Module: fma16_align_add

Interface
REQ-001: Block SHALL have no parameters; all widths fixed as listed.
REQ-002: clk  input  1  sole clock, all state on rising edge.
REQ-003: reset_n  input  1  asynchronous active-low reset.
REQ-004: in_valid  input  1  product/addend beat present.
REQ-005: in_ready  output  1  block accepts beat this cycle.
REQ-006: p_sign  input  1  product sign from multiplier stage.
REQ-007: p_exp  input  7  product exponent, two's complement, biased 15 (xe+ye-15 + carry, unclamped).
REQ-008: p_frac  input  22  full product significand, 2.20 fixed point.
REQ-009: z  input  16  addend, IEEE half (sign, 5-bit exp, 10-bit frac).
REQ-010: out_valid  output  1  result beat present.
REQ-011: out_ready  input  1  downstream accepts result.
REQ-012: s_sign, s_exp[6:0], s_mag[22:0] (3.20), s_sticky, s_zero  outputs  unnormalized sum fields for round/normalize stage.

Function
REQ-013: Addend significand SHALL be {zexp!=0, z[9:0]} extended to 2.20 as {1'b0, sig, 10'b0}; ze = zexp, or 1 when zexp==0.
REQ-014: Stage 1 SHALL compute d = p_exp - ze (signed 8-bit) and register the aligned operands.
- d>=0: addend shifted right by d; result exp = p_exp.
- d<0: product shifted right by -d; result exp = ze.
- Shift >= 24 SHALL zero the operand entirely.
REQ-015: Stage 2 SHALL add magnitudes when p_sign==z[15], else subtract; a negative difference SHALL be negated and the larger operand's sign taken.
REQ-016: Exact zero sum SHALL give s_mag=0, s_zero=1, s_sign=0, regardless of s_sticky.
REQ-017: Latency SHALL be exactly 2 cycles from accepted beat to out_valid with no stalls; throughput 1 beat/cycle.
REQ-018: Stage 2 SHALL load when empty or out_ready=1; stage 1 SHALL advance when empty or stage 2 loads; in_ready = !s1_valid | s1_advance.
REQ-019: While out_valid=1 and out_ready=0, all output fields SHALL hold stable.
REQ-020: Beats SHALL leave in acceptance order; none dropped or duplicated under any stall pattern.
REQ-021: Simultaneous accept and emit with both stages full SHALL proceed without a bubble.
REQ-022: Exponent SHALL never be clamped or flagged here; under/overflow is decided downstream.

Reset
REQ-023: reset_n low SHALL immediately clear both stage valids; out_valid=0, in_ready=1 during reset.
REQ-024: Output data fields SHALL reset to 0 (s_sign, s_exp, s_mag, s_sticky, s_zero).
REQ-025: Reset asserted mid-transfer SHALL discard in-flight beats; first beat after release follows REQ-017.

Configuration
REQ-026: Macro FMA16_STICKY_EN defined: bits shifted out in REQ-014 SHALL be OR-reduced into s_sticky (subtract path: sticky also forces a borrow of one LSB on the larger operand).
REQ-027: Macro undefined: shifted-out bits SHALL be discarded, s_sticky tied 0, no sticky logic synthesized.

Verification
REQ-028: p_sign=0, p_exp=15, p_frac=0x100000, z=0x3C00 -> after 2 cycles s_mag=0x200000, s_exp=15, s_sign=0, s_sticky=0, s_zero=0.
REQ-029: same product, z=0xBC00 -> s_mag=0, s_zero=1, s_sign=0.
REQ-030: p_exp=15, p_frac=0x100000, z=0x0401 (d=14) -> s_mag=0x100040, s_exp=15; s_sticky=1 with FMA16_STICKY_EN, 0 without.
REQ-031: Four back-to-back beats, out_ready low cycles 2-5 -> in_ready falls once both stages full; outputs hold; all four emerge in order, no gaps once out_ready=1.
REQ-032: p_exp=-20 (0x6C), p_frac=0x100000, z=0x3C00 -> product fully shifted out; s_mag=0x100000, s_exp=15, s_sticky=1 (macro on).
REQ-033: reset_n pulsed low while two beats in flight -> out_valid=0 same cycle; no stale beat emitted after release.
